amstrad_ram_sequencer: RTL and testbench
========================================

AMSTRAD_RAM_SEQUENCER -- requirements
Module: amstrad_ram_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 23, meaning the RAM byte address width.
REQ-002 The block SHALL have parameter RAM_LAT, default 2, meaning the ce_16 ticks from strobe issue to valid ram_din; legal range 1..3.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port ce_16, input, 1 bit: 16 MHz clock enable.
REQ-006 The block SHALL have port no_wait, input, 1 bit: forces wait_n high while sequencing continues.
REQ-007 The block SHALL have port cpu_req, input, 1 bit: level request from the CPU bus.
REQ-008 The block SHALL have port cpu_io, input, 1 bit: the request is I/O, with no RAM strobe.
REQ-009 The block SHALL have port cpu_we, input, 1 bit: write when high.
REQ-010 The block SHALL have ports cpu_addr (input, ADDR_W bits, mapped byte address) and cpu_dout (input, 8 bits, write data).
REQ-011 The block SHALL have ports cpu_din (output, 8 bits, latched read data), cpu_ack (output, 1-clk done pulse) and wait_n (output, 1 bit, CPU wait, active-low).
REQ-012 The block SHALL have ports vid_addr (input, 15 bits, CRTC word address), vid_data (output, 16 bits, {high byte, low byte}) and vid_valid (output, 1-clk pulse).
REQ-013 The block SHALL have ports ram_addr (output, ADDR_W), ram_dout (output, 8), ram_din (input, 8), ram_oe (output, 1) and ram_we (output, 1).
REQ-014 The block SHALL have port cyc1mhz, output, 1 bit: 1 MHz slot marker.

Function
REQ-015 A 4-bit phase counter ph SHALL advance on each ce_16 and wrap from 15 to 0; cyc1mhz SHALL be high for exactly the clk in which ce_16=1 and ph=15.
REQ-016 The slot map SHALL be: ph 0 = video low-byte strobe; ph 4 = video high-byte strobe; ph 8 = CPU strobe; all other phases idle.
REQ-017 Video strobes SHALL be unconditional: ram_addr = {zeros, vid_addr, 0} at ph 0 and {zeros, vid_addr, 1} at ph 4, with ram_oe=1 and ram_we=0 for one ce_16 tick; vid_addr SHALL be sampled at ph 0 only.
REQ-018 The low byte SHALL be latched at ph 0+RAM_LAT and the high byte at ph 4+RAM_LAT; vid_valid SHALL pulse for 1 clk immediately after the high-byte latch.
REQ-019 The CPU FSM SHALL have states IDLE, PEND, ACC and DONE.
REQ-020 IDLE->PEND SHALL occur on cpu_req=1 when the armed flag is set; armed SHALL clear on this transition and set again only when cpu_req=0.
REQ-021 In PEND, wait_n SHALL be 0 from the clk after cpu_req is sampled, unless no_wait=1.
REQ-022 PEND->ACC SHALL occur only at ce_16 with ph=8; a request arriving at ph 8..15 after the strobe point SHALL wait for the next 1 MHz cycle.
REQ-023 In ACC for a RAM request: ram_addr=cpu_addr, ram_we=cpu_we, ram_oe=~cpu_we and ram_dout=cpu_dout for one ce_16 tick.
REQ-024 For a read, cpu_din SHALL be latched at ph 8+RAM_LAT.
REQ-025 For I/O (cpu_io=1), ACC SHALL issue no ram_oe or ram_we and SHALL complete at ph 8+RAM_LAT.
REQ-026 ACC->DONE: cpu_ack SHALL pulse 1 clk and wait_n SHALL return to 1 in the same clk; DONE->IDLE SHALL follow on the next clk.
REQ-027 cpu_addr, cpu_we, cpu_io and cpu_dout SHALL be captured at PEND entry; later changes SHALL be ignored.
REQ-028 Video and CPU strobes SHALL never overlap; at most one of ram_oe and ram_we SHALL be high at any time.
REQ-029 A cpu_req held high after cpu_ack SHALL NOT start a second access.

Reset
REQ-030 While reset_n=0: ph=0, FSM=IDLE, armed=1, wait_n=1, cpu_ack=0, vid_valid=0, cyc1mhz=0, ram_oe=0, ram_we=0, and ram_addr, ram_dout, cpu_din and vid_data all 0.
REQ-031 Reset asserted mid-access SHALL abort the access with no ram_we pulse after assertion; after release the first ce_16 SHALL be treated as ph 0.

Verification
REQ-032 Video fetch: vid_addr=15'h1234, RAM returns 8'hAA then 8'h55 -> ram_addr=16'h2468 at ph 0 and 16'h2469 at ph 4; vid_data=16'h55AA with vid_valid at ph 6+1 clk.
REQ-033 CPU read: cpu_req at ph 2, cpu_addr=23'h004000, RAM returns 8'h3C -> wait_n low until ph 10; cpu_din=8'h3C; exactly one cpu_ack.
REQ-034 Late request: cpu_req at ph 9 -> no strobe until the next cycle's ph 8; wait_n low for about 15 ce_16 ticks.
REQ-035 Held request with cpu_we=1 and cpu_dout=8'h77 -> one ram_we pulse only; a new access starts only after cpu_req falls and rises again.
REQ-036 no_wait=1 with an I/O request -> wait_n stays 1; cpu_ack at ph 10; no ram_oe or ram_we during the CPU slot.
REQ-037 reset_n pulsed low at ph 8 of a write -> ram_we=0 from assertion; all outputs at their reset values; ph restarts at 0.

Source files
------------

// File: rtl/amstrad_ram_sequencer.sv
// ============================================================================
// Module      : amstrad_ram_sequencer
// Description : 16-phase time-division RAM sequencer sharing one byte-wide RAM
//               between CRTC video fetch (ph 0/4) and the CPU slot (ph 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amstrad_ram_sequencer #(
  parameter int ADDR_W  = 23,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_16,
  input  logic              no_wait,
  input  logic              cpu_req,
  input  logic              cpu_io,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic              wait_n,
  input  logic [14:0]       vid_addr,
  output logic [15:0]       vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              cyc1mhz
);

  localparam logic [3:0] c_PH_VID_LO = 4'd0;
  localparam logic [3:0] c_PH_VID_HI = 4'd4;
  localparam logic [3:0] c_PH_CPU    = 4'd8;
  localparam logic [3:0] c_LAT_VLO   = 4'(RAM_LAT);
  localparam logic [3:0] c_LAT_VHI   = 4'(4 + RAM_LAT);
  localparam logic [3:0] c_LAT_CPU   = 4'(8 + RAM_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_ph;
  logic                r_armed;
  logic [ADDR_W-1:0]   r_cpu_addr;
  logic                r_cpu_we;
  logic                r_cpu_io;
  logic [7:0]          r_cpu_dout;
  logic [7:0]          r_cpu_din;
  logic [14:0]         r_vid_addr;
  logic [7:0]          r_vid_lo;
  logic [15:0]         r_vid_data;
  logic                r_vid_valid;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [7:0]          r_ram_dout;
  logic                r_ram_oe;
  logic                r_ram_we;
  logic                w_start;
  logic                w_cpu_slot;
  logic                w_cpu_done;
  logic                w_busy;
  logic                w_ack;

  assign w_start    = (r_state == S_IDLE) && cpu_req && r_armed;
  assign w_cpu_slot = ce_16 && (r_ph == c_PH_CPU);
  assign w_cpu_done = ce_16 && (r_ph == c_LAT_CPU);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      S_IDLE: if (cpu_req && r_armed) w_next_state = S_PEND;
      S_PEND: begin
        w_busy = 1'b1;
        if (w_cpu_slot) w_next_state = S_ACC;
      end
      S_ACC: begin
        w_busy = 1'b1;
        if (w_cpu_done) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_ack        = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ph        <= 4'd0;
      r_armed     <= 1'b1;
      r_cpu_addr  <= '0;
      r_cpu_we    <= 1'b0;
      r_cpu_io    <= 1'b0;
      r_cpu_dout  <= 8'h00;
      r_cpu_din   <= 8'h00;
      r_vid_addr  <= 15'h0000;
      r_vid_lo    <= 8'h00;
      r_vid_data  <= 16'h0000;
      r_vid_valid <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_dout  <= 8'h00;
      r_ram_oe    <= 1'b0;
      r_ram_we    <= 1'b0;
    end else begin
      r_vid_valid <= 1'b0;
      // Re-arm only once the CPU drops its level request, so a held request runs once.
      if (!cpu_req)     r_armed <= 1'b1;
      else if (w_start) r_armed <= 1'b0;
      if (w_start) begin
        r_cpu_addr <= cpu_addr;
        r_cpu_we   <= cpu_we;
        r_cpu_io   <= cpu_io;
        r_cpu_dout <= cpu_dout;
      end
      if (ce_16) begin
        r_ph     <= r_ph + 4'd1;
        r_ram_oe <= 1'b0;
        r_ram_we <= 1'b0;
        if (r_ph == c_PH_VID_LO) begin
          r_vid_addr <= vid_addr;
          r_ram_addr <= {{(ADDR_W-16){1'b0}}, vid_addr, 1'b0};
          r_ram_oe   <= 1'b1;
        end else if (r_ph == c_PH_VID_HI) begin
          r_ram_addr <= {{(ADDR_W-16){1'b0}}, r_vid_addr, 1'b1};
          r_ram_oe   <= 1'b1;
        end else if (r_ph == c_PH_CPU && r_state == S_PEND && !r_cpu_io) begin
          r_ram_addr <= r_cpu_addr;
          r_ram_dout <= r_cpu_dout;
          r_ram_oe   <= ~r_cpu_we;
          r_ram_we   <= r_cpu_we;
        end
        if (r_ph == c_LAT_VLO) r_vid_lo <= ram_din;
        if (r_ph == c_LAT_VHI) begin
          r_vid_data  <= {ram_din, r_vid_lo};
          r_vid_valid <= 1'b1;
        end
        if (r_ph == c_LAT_CPU && r_state == S_ACC && !r_cpu_io && !r_cpu_we)
          r_cpu_din <= ram_din;
      end
    end
  end

  assign cpu_din   = r_cpu_din;
  assign cpu_ack   = w_ack;
  assign wait_n    = ~w_busy | no_wait;
  assign vid_data  = r_vid_data;
  assign vid_valid = r_vid_valid;
  assign ram_addr  = r_ram_addr;
  assign ram_dout  = r_ram_dout;
  assign ram_oe    = r_ram_oe;
  assign ram_we    = r_ram_we;
  assign cyc1mhz   = ce_16 && (r_ph == 4'hF);

endmodule

`default_nettype wire

// File: tb/tb_amstrad_ram_sequencer.sv
// ============================================================================
// Module      : tb_amstrad_ram_sequencer
// Description : Scoreboard bench for amstrad_ram_sequencer (video + CPU slots).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_amstrad_ram_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_16 = 1'b0;
  logic        no_wait = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_io = 1'b0;
  logic        cpu_we = 1'b0;
  logic [22:0] cpu_addr = 23'h0;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic        wait_n;
  logic [14:0] vid_addr = 15'h1234;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic [22:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        ram_oe;
  logic        ram_we;
  logic        cyc1mhz;

  typedef struct {logic [22:0] addr; logic we; logic [7:0] dout;} strb_t;
  typedef struct {logic rd; logic [7:0] din; int wclk;} resp_t;

  strb_t       sq[$];
  resp_t       rq[$];
  logic [15:0] vq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [3:0]  tb_ph = 4'd0;
  logic [14:0] tb_vaddr = 15'h0;

  amstrad_ram_sequencer #(.ADDR_W(23), .RAM_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .ce_16(ce_16), .no_wait(no_wait),
    .cpu_req(cpu_req), .cpu_io(cpu_io), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack), .wait_n(wait_n),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_oe(ram_oe), .ram_we(ram_we), .cyc1mhz(cyc1mhz)
  );

  always #5 clk = ~clk;

  // ce_16 on every other clock, changing just after the rising edge.
  initial forever begin
    @(posedge clk);
    #1 ce_16 = ~ce_16;
  end

  function automatic logic [7:0] memf(input logic [22:0] a);
    case (a)
      23'h002468: memf = 8'hAA;
      23'h002469: memf = 8'h55;
      23'h004000: memf = 8'h3C;
      default:    memf = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  assign ram_din = memf(ram_addr);

  // Reference 1 MHz slot counter; pushes the expected video word at each ph 0 tick.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ph <= 4'd0;
    else if (ce_16) begin
      tb_ph <= tb_ph + 4'd1;
      if (tb_ph == 4'd0) begin
        tb_vaddr <= vid_addr;
        vq.push_back({memf({7'b0, vid_addr, 1'b1}), memf({7'b0, vid_addr, 1'b0})});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: strobes, video words and CPU completions checked against the queues.
  initial begin : monitor
    logic  p_strb;
    logic  p_vv;
    logic  p_ack;
    int    wcnt;
    strb_t s;
    resp_t r;
    logic [15:0] v;
    p_strb = 1'b0; p_vv = 1'b0; p_ack = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_strb = 1'b0; p_vv = 1'b0; p_ack = 1'b0; wcnt = 0;
      end else begin
        if (ram_oe && ram_we) chk("oe_we_exclusive", 32'({ram_oe, ram_we}), 32'b10);
        if ((ram_oe || ram_we) && !p_strb) begin
          if (tb_ph == 4'd1 || tb_ph == 4'd5) begin
            chk("vid_strobe_addr", 32'(ram_addr), 32'({7'b0, tb_vaddr, (tb_ph == 4'd5)}));
            chk("vid_strobe_oe_we", 32'({ram_oe, ram_we}), 32'b10);
          end else if (tb_ph == 4'd9) begin
            chk("cpu_strobe_expected", 32'(sq.size() != 0), 32'd1);
            if (sq.size() != 0) begin
              s = sq.pop_front();
              chk("cpu_strobe_addr", 32'(ram_addr), 32'(s.addr));
              chk("cpu_strobe_oe_we", 32'({ram_oe, ram_we}), 32'({~s.we, s.we}));
              if (s.we) chk("cpu_strobe_dout", 32'(ram_dout), 32'(s.dout));
            end
          end else begin
            chk("strobe_phase", 32'(tb_ph), 32'd9);
          end
        end
        if (vid_valid) begin
          chk("vid_valid_width", 32'(p_vv), 32'd0);
          chk("vid_valid_phase", 32'(tb_ph), 32'd7);
          chk("vid_expected", 32'(vq.size() != 0), 32'd1);
          if (vq.size() != 0) begin
            v = vq.pop_front();
            chk("vid_data", 32'(vid_data), 32'(v));
          end
        end
        if (cpu_ack) begin
          chk("ack_width", 32'(p_ack), 32'd0);
          chk("ack_wait_n", 32'(wait_n), 32'd1);
          chk("ack_phase", 32'(tb_ph), 32'd11);
          chk("ack_expected", 32'(rq.size() != 0), 32'd1);
          if (rq.size() != 0) begin
            r = rq.pop_front();
            chk("wait_low_clks", 32'(wcnt), 32'(r.wclk));
            if (r.rd) chk("cpu_din", 32'(cpu_din), 32'(r.din));
          end
          wcnt = 0;
        end
        if (!wait_n) wcnt++;
        p_strb = ram_oe || ram_we;
        p_vv   = vid_valid;
        p_ack  = cpu_ack;
      end
    end
  end

  task automatic at_ph(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ce_16 && tb_ph == 4'(p)) && n < 200);
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL at_ph_timeout: phase %0d not reached, at %0d", p, tb_ph);
    end
  endtask

  task automatic wait_ack(input int lim);
    int n;
    n = 0;
    while (!cpu_ack && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ack) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: cpu_ack=%0b required 1 within %0d clks", cpu_ack, lim);
    end
  endtask

  task automatic check_reset();
    chk("rst_wait_n", 32'(wait_n), 32'd1);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_cyc1mhz", 32'(cyc1mhz), 32'd0);
    chk("rst_ram_oe", 32'(ram_oe), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_cpu_din", 32'(cpu_din), 32'd0);
    chk("rst_vid_data", 32'(vid_data), 32'd0);
  endtask

  initial begin : stim
    int n;
    repeat (4) @(negedge clk);
    check_reset();
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    // CPU read at ph 2
    at_ph(2);
    cpu_addr = 23'h004000; cpu_we = 1'b0; cpu_io = 1'b0; cpu_req = 1'b1;
    sq.push_back('{addr: 23'h004000, we: 1'b0, dout: 8'h00});
    rq.push_back('{rd: 1'b1, din: 8'h3C, wclk: 16});
    wait_ack(100);
    cpu_req = 1'b0;

    // vid_addr changed after its ph 0 sample; late CPU read at ph 9
    at_ph(2);
    vid_addr = 15'h0100;
    at_ph(9);
    cpu_addr = 23'h000010; cpu_req = 1'b1;
    sq.push_back('{addr: 23'h000010, we: 1'b0, dout: 8'h00});
    rq.push_back('{rd: 1'b1, din: 8'hB5, wclk: 34});
    wait_ack(100);
    cpu_req = 1'b0;

    // Held write; inputs changed after capture must be ignored
    at_ph(3);
    cpu_addr = 23'h001234; cpu_dout = 8'h77; cpu_we = 1'b1; cpu_req = 1'b1;
    sq.push_back('{addr: 23'h001234, we: 1'b1, dout: 8'h77});
    rq.push_back('{rd: 1'b0, din: 8'h00, wclk: 14});
    repeat (2) @(negedge clk);
    cpu_addr = 23'h7FFFFF; cpu_dout = 8'hEE; cpu_we = 1'b0;
    wait_ack(100);
    repeat (100) @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    at_ph(12);
    cpu_addr = 23'h001235; cpu_dout = 8'h88; cpu_we = 1'b1; cpu_req = 1'b1;
    sq.push_back('{addr: 23'h001235, we: 1'b1, dout: 8'h88});
    rq.push_back('{rd: 1'b0, din: 8'h00, wclk: 28});
    wait_ack(100);
    cpu_req = 1'b0; cpu_we = 1'b0;

    // I/O request with no_wait: no RAM strobe, wait_n never low
    at_ph(1);
    no_wait = 1'b1; cpu_io = 1'b1; cpu_addr = 23'h000055; cpu_req = 1'b1;
    rq.push_back('{rd: 1'b0, din: 8'h00, wclk: 0});
    wait_ack(100);
    cpu_req = 1'b0; no_wait = 1'b0; cpu_io = 1'b0;

    // Reset asserted while the write strobe is active
    at_ph(5);
    cpu_addr = 23'h000300; cpu_dout = 8'h99; cpu_we = 1'b1; cpu_req = 1'b1;
    sq.push_back('{addr: 23'h000300, we: 1'b1, dout: 8'h99});
    n = 0;
    while (!ram_we && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ram_we) begin
      n_tests++; n_fail++;
      $display("FAIL write_strobe_timeout: ram_we=%0b required 1", ram_we);
    end
    #2 reset_n = 1'b0;
    #1 check_reset();
    sq.delete(); rq.delete(); vq.delete();
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    reset_n = 1'b1;
    repeat (70) @(negedge clk);

    chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
